// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
//   rf_data_t / rf_addr_t : default-width data and address types (16 x 16-bit).
//   rf_aw()               : address width for a given register count.
//   RF_ZERO_ADDR          : index of the optional hardwired-zero register.
package regfile_pkg;
    localparam int RF_DW_DEFAULT    = 16;
    localparam int RF_NREGS_DEFAULT = 16;
    localparam int RF_ZERO_ADDR     = 0;

    typedef logic [RF_DW_DEFAULT-1:0]             rf_data_t;
    typedef logic [$clog2(RF_NREGS_DEFAULT)-1:0]  rf_addr_t;

    function automatic int rf_aw(input int num_regs);
        return $clog2(num_regs);
    endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for register_file_mp: one flop per register.
//   clk, rst         : clock, async active-high reset (clears all busy bits)
//   we, waddr        : writeback ports; a write clears busy for its register
//   rsv_en, rsv_addr : issue reservation; sets busy, overriding a same-cycle clear
//   busy_vec         : registered busy bits
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NumRegs       = 16,
    parameter int NumWritePorts = 2,
    parameter bit ZeroReg       = 1'b0,
    localparam int AW           = rf_aw(NumRegs)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NumWritePorts-1:0]          we,
    input  logic [NumWritePorts-1:0][AW-1:0]  waddr,
    input  logic                              rsv_en,
    input  logic [AW-1:0]                     rsv_addr,
    output logic [NumRegs-1:0]                busy_vec
);
    logic [NumRegs-1:0] r_busy;
    logic [NumRegs-1:0] w_busy_nxt;
    logic               w_rsv_ok;

    // The zero register never becomes busy.
    assign w_rsv_ok = rsv_en && !(ZeroReg && (rsv_addr == AW'(RF_ZERO_ADDR)));

    always_comb begin
        w_busy_nxt = r_busy;
        for (int k = 0; k < NumWritePorts; k++) begin
            if (we[k]) w_busy_nxt[waddr[k]] = 1'b0;
        end
        // Applied after the clears: the newly issued producer owns the register.
        if (w_rsv_ok) w_busy_nxt[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_busy <= '0;
        else     r_busy <= w_busy_nxt;
    end

    assign busy_vec = r_busy;
endmodule

// File: rtl/register_file_mp.sv
// Multi-port GPR store with same-cycle write bypass, optional hardwired-zero
// register and a per-register busy scoreboard.
//   clk, rst         : clock, async active-high reset (clears regs and busy)
//   we/waddr/wdata   : write ports; higher index wins on address conflict
//   raddr -> rdata   : combinational read ports, 0-cycle latency
//   rd_busy          : busy status of each read address, masked by a same-cycle write
//   rsv_en/rsv_addr  : reserve (mark busy) a destination register
//   busy_vec         : registered scoreboard
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int DataWidth     = 16,
    parameter int NumRegs       = 16,
    parameter int NumReadPorts  = 2,
    parameter int NumWritePorts = 2,
    parameter bit ZeroReg       = 1'b0,
    parameter bit Bypass        = 1'b1,
    localparam int AW           = rf_aw(NumRegs)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NumWritePorts-1:0]                we,
    input  logic [NumWritePorts-1:0][AW-1:0]        waddr,
    input  logic [NumWritePorts-1:0][DataWidth-1:0] wdata,
    input  logic [NumReadPorts-1:0][AW-1:0]         raddr,
    output logic [NumReadPorts-1:0][DataWidth-1:0]  rdata,
    output logic [NumReadPorts-1:0]                 rd_busy,
    input  logic                                    rsv_en,
    input  logic [AW-1:0]                           rsv_addr,
    output logic [NumRegs-1:0]                      busy_vec
);
    logic [NumRegs-1:0][DataWidth-1:0]      r_regs;
    logic [NumReadPorts-1:0]                w_hit;
    logic [NumReadPorts-1:0][DataWidth-1:0] w_byp;

    // Ascending port order: the last NBA to a given register wins, giving
    // the highest enabled port priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regs <= '0;
        end else begin
            for (int k = 0; k < NumWritePorts; k++) begin
                if (we[k] && !(ZeroReg && (waddr[k] == AW'(RF_ZERO_ADDR))))
                    r_regs[waddr[k]] <= wdata[k];
            end
        end
    end

    regfile_scoreboard #(
        .NumRegs      (NumRegs),
        .NumWritePorts(NumWritePorts),
        .ZeroReg      (ZeroReg)
    ) u_sb (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (waddr),
        .rsv_en  (rsv_en),
        .rsv_addr(rsv_addr),
        .busy_vec(busy_vec)
    );

    always_comb begin
        for (int i = 0; i < NumReadPorts; i++) begin
            w_hit[i] = 1'b0;
            w_byp[i] = '0;
            // Same ascending scan as the write path so bypass matches the stored value.
            for (int k = 0; k < NumWritePorts; k++) begin
                if (we[k] && (waddr[k] == raddr[i])) begin
                    w_hit[i] = 1'b1;
                    w_byp[i] = wdata[k];
                end
            end
            rdata[i] = (Bypass && w_hit[i]) ? w_byp[i] : r_regs[raddr[i]];
            // Zero register and reset override the bypass path as well.
            if (ZeroReg && (raddr[i] == AW'(RF_ZERO_ADDR))) rdata[i] = '0;
            if (rst) rdata[i] = '0;
            rd_busy[i] = !rst && busy_vec[raddr[i]] && !(Bypass && w_hit[i]);
        end
    end
endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;
    import regfile_pkg::*;

    typedef struct {
        logic [1:0]  we;
        logic [3:0]  wa0, wa1;
        logic [15:0] wd0, wd1;
        logic [3:0]  ra0, ra1;
        logic        rsv;
        logic [3:0]  rsva;
        logic [15:0] e_rd0, e_rd1;
        logic [1:0]  e_rb;
        logic [15:0] e_bv;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        we = '0;
    logic [1:0][3:0]   waddr = '0;
    logic [1:0][15:0]  wdata = '0;
    logic [1:0][3:0]   raddr = '0;
    logic              rsv_en = 1'b0;
    logic [3:0]        rsv_addr = '0;
    logic [1:0][15:0]  rdata, rdata_nb;
    logic [1:0]        rd_busy, rd_busy_nb;
    logic [15:0]       busy_vec, busy_vec_nb;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] q_bv[$];
    rf_data_t    m_regs[16];
    logic [15:0] m_busy;
    vec_t        tbl[14];

    always #5 clk = ~clk;

    register_file_mp #(.DataWidth(16), .NumRegs(16), .NumReadPorts(2), .NumWritePorts(2),
                       .ZeroReg(1'b1), .Bypass(1'b1)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(rdata), .rd_busy(rd_busy), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy_vec(busy_vec));

    register_file_mp #(.DataWidth(16), .NumRegs(16), .NumReadPorts(2), .NumWritePorts(2),
                       .ZeroReg(1'b0), .Bypass(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(rdata_nb), .rd_busy(rd_busy_nb), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy_vec(busy_vec_nb));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [1:0] w, logic [3:0] a0, logic [15:0] d0,
                                logic [3:0] a1, logic [15:0] d1, logic [3:0] r0,
                                logic [3:0] r1, logic rs, logic [3:0] rsa,
                                logic [15:0] e0, logic [15:0] e1, logic [1:0] eb,
                                logic [15:0] ebv);
        vec_t v;
        v.we = w; v.wa0 = a0; v.wd0 = d0; v.wa1 = a1; v.wd1 = d1;
        v.ra0 = r0; v.ra1 = r1; v.rsv = rs; v.rsva = rsa;
        v.e_rd0 = e0; v.e_rd1 = e1; v.e_rb = eb; v.e_bv = ebv;
        return v;
    endfunction

    // Drive at negedge, queue the expected post-edge scoreboard, let comb settle.
    task automatic drive(input vec_t v);
        @(negedge clk);
        we = v.we; waddr[0] = v.wa0; waddr[1] = v.wa1;
        wdata[0] = v.wd0; wdata[1] = v.wd1;
        raddr[0] = v.ra0; raddr[1] = v.ra1;
        rsv_en = v.rsv; rsv_addr = v.rsva;
        q_bv.push_back(v.e_bv);
        #1;
    endtask

    task automatic edge_chk(input string name);
        logic [15:0] e;
        @(posedge clk);
        #1;
        if (q_bv.size() == 0) begin
            chk({name, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = q_bv.pop_front();
            chk({name, "_busy_vec"}, {16'd0, busy_vec}, {16'd0, e});
        end
    endtask

    task automatic idle();
        @(negedge clk);
        we = '0; rsv_en = 1'b0;
    endtask

    initial begin
        // Directed table; registers and scoreboard start cleared.
        tbl[0]  = mk(2'b11, 3, 16'h1111, 3, 16'h2222, 3, 0, 0, 0, 16'h2222, 16'h0000, 2'b00, 16'h0000);
        tbl[1]  = mk(2'b00, 0, 0, 0, 0, 3, 3, 0, 0, 16'h2222, 16'h2222, 2'b00, 16'h0000);
        tbl[2]  = mk(2'b11, 0, 16'hFFFF, 0, 16'hFFFF, 0, 0, 1, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000);
        tbl[3]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000);
        tbl[4]  = mk(2'b00, 0, 0, 0, 0, 3, 7, 1, 7, 16'h2222, 16'h0000, 2'b00, 16'h0080);
        tbl[5]  = mk(2'b00, 0, 0, 0, 0, 3, 7, 0, 0, 16'h2222, 16'h0000, 2'b10, 16'h0080);
        tbl[6]  = mk(2'b01, 7, 16'h00AA, 0, 0, 3, 7, 0, 0, 16'h2222, 16'h00AA, 2'b00, 16'h0000);
        tbl[7]  = mk(2'b01, 9, 16'h5A5A, 0, 0, 9, 7, 1, 9, 16'h5A5A, 16'h00AA, 2'b00, 16'h0200);
        tbl[8]  = mk(2'b00, 0, 0, 0, 0, 9, 7, 0, 0, 16'h5A5A, 16'h00AA, 2'b01, 16'h0200);
        tbl[9]  = mk(2'b00, 0, 0, 0, 0, 9, 7, 1, 9, 16'h5A5A, 16'h00AA, 2'b01, 16'h0200);
        tbl[10] = mk(2'b11, 9, 16'h4321, 9, 16'h1234, 9, 5, 1, 5, 16'h1234, 16'h0000, 2'b00, 16'h0020);
        tbl[11] = mk(2'b01, 5, 16'hBEEF, 0, 0, 5, 9, 0, 0, 16'hBEEF, 16'h1234, 2'b00, 16'h0000);
        tbl[12] = mk(2'b10, 0, 0, 2, 16'h0002, 5, 2, 0, 0, 16'hBEEF, 16'h0002, 2'b00, 16'h0000);
        tbl[13] = mk(2'b11, 1, 16'h0101, 0, 16'hABCD, 1, 0, 0, 0, 16'h0101, 16'h0000, 2'b00, 16'h0000);

        // Reset state, including a write presented while reset is held.
        @(negedge clk);
        we = 2'b01; waddr[0] = 4'd5; wdata[0] = 16'hCAFE; raddr[0] = 4'd5; raddr[1] = 4'd5;
        rsv_en = 1'b1; rsv_addr = 4'd5;
        #1;
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rd_busy", {30'd0, rd_busy}, 32'd0);
        @(posedge clk); #1;
        chk("rst_busy_vec", {16'd0, busy_vec}, 32'd0);
        idle();
        rst = 1'b0;

        for (int t = 0; t < 14; t++) begin
            drive(tbl[t]);
            chk($sformatf("v%0d_rdata0", t), {16'd0, rdata[0]}, {16'd0, tbl[t].e_rd0});
            chk($sformatf("v%0d_rdata1", t), {16'd0, rdata[1]}, {16'd0, tbl[t].e_rd1});
            chk($sformatf("v%0d_rd_busy", t), {30'd0, rd_busy}, {30'd0, tbl[t].e_rb});
            edge_chk($sformatf("v%0d", t));
        end

        // No-bypass build: old value in the write cycle, new value next cycle.
        drive(mk(2'b01, 4, 16'h1234, 0, 0, 4, 0, 0, 0, 0, 0, 0, 16'h0000));
        chk("nb_same_cycle_old", {16'd0, rdata_nb[0]}, 32'h0000);
        chk("byp_same_cycle_new", {16'd0, rdata[0]}, 32'h1234);
        edge_chk("nb_w");
        drive(mk(2'b00, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 16'h0000));
        chk("nb_next_cycle_new", {16'd0, rdata_nb[0]}, 32'h1234);
        edge_chk("nb_r");

        // Mid-cycle async reset with r5=BEEF and r6 busy; pending ops discarded.
        drive(mk(2'b00, 0, 0, 0, 0, 5, 6, 1, 6, 0, 0, 0, 16'h0040));
        chk("pre_rst_r5", {16'd0, rdata[0]}, 32'hBEEF);
        edge_chk("pre_rst");
        @(negedge clk);
        we = 2'b01; waddr[0] = 4'd5; wdata[0] = 16'h7777; rsv_en = 1'b1; rsv_addr = 4'd8;
        raddr[0] = 4'd5; raddr[1] = 4'd6;
        #1 rst = 1'b1;
        #1;
        chk("midrst_rdata0", {16'd0, rdata[0]}, 32'd0);
        chk("midrst_rd_busy", {30'd0, rd_busy}, 32'd0);
        chk("midrst_busy_vec", {16'd0, busy_vec}, 32'd0);
        @(posedge clk); #1;
        chk("midrst_edge_busy", {16'd0, busy_vec}, 32'd0);
        idle();
        rst = 1'b0;
        #1;
        chk("postrst_r5", {16'd0, rdata[0]}, 32'd0);
        chk("postrst_r6_busy", {30'd0, rd_busy}, 32'd0);

        // Randomised traffic against a reference model.
        for (int r = 0; r < 16; r++) m_regs[r] = '0;
        m_busy = '0;
        for (int c = 0; c < 300; c++) begin
            vec_t v;
            logic [15:0] e_rd[2];
            logic [1:0]  e_rb;
            logic [3:0]  ra[2];
            v = mk($urandom_range(0, 3), $urandom_range(0, 15), $urandom, $urandom_range(0, 15),
                   $urandom, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1),
                   $urandom_range(0, 15), 0, 0, 0, 0);
            if ($urandom_range(0, 2) == 0) v.ra0 = v.wa1;
            if ($urandom_range(0, 2) == 0) v.ra1 = v.wa0;
            ra[0] = v.ra0; ra[1] = v.ra1;
            for (int i = 0; i < 2; i++) begin
                logic hit;
                hit = 1'b0;
                e_rd[i] = m_regs[ra[i]];
                if (v.we[0] && v.wa0 == ra[i]) begin hit = 1'b1; e_rd[i] = v.wd0; end
                if (v.we[1] && v.wa1 == ra[i]) begin hit = 1'b1; e_rd[i] = v.wd1; end
                if (ra[i] == 4'd0) e_rd[i] = '0;
                e_rb[i] = m_busy[ra[i]] & ~hit;
            end
            if (v.we[0] && v.wa0 != 0) m_regs[v.wa0] = v.wd0;
            if (v.we[1] && v.wa1 != 0) m_regs[v.wa1] = v.wd1;
            if (v.we[0]) m_busy[v.wa0] = 1'b0;
            if (v.we[1]) m_busy[v.wa1] = 1'b0;
            if (v.rsv && v.rsva != 0) m_busy[v.rsva] = 1'b1;
            v.e_bv = m_busy;
            drive(v);
            chk("rnd_rdata0", {16'd0, rdata[0]}, {16'd0, e_rd[0]});
            chk("rnd_rdata1", {16'd0, rdata[1]}, {16'd0, e_rd[1]});
            chk("rnd_rd_busy", {30'd0, rd_busy}, {30'd0, e_rb});
            edge_chk("rnd");
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
